// File: rtl/serdes_pkg.sv
// Shared definitions for the 10-bit serial link receive path.
//   K28_5_RDN / K28_5_RDP : K28.5 comma in LSB-first order (RD- / RD+)
//   WORD_W                : code-group width
//   align_state_t         : word-alignment FSM states
package serdes_pkg;

    localparam int WORD_W = 10;
    localparam logic [WORD_W-1:0] K28_5_RDN = 10'h17C;
    localparam logic [WORD_W-1:0] K28_5_RDP = 10'h283;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

endpackage

// File: rtl/rx_word_align_comma_detect.sv
// comma_detect: flags a 10-bit window equal to either K28.5 disparity variant.
//   word  in  10  candidate window, bit 0 = oldest bit
//   comma out 1   window is a K28.5 comma
module comma_detect
    import serdes_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic              comma
);

    assign comma = (word == K28_5_RDN) || (word == K28_5_RDP);

endmodule

// File: rtl/rx_word_align.sv
// rx_word_align: hunts for K28.5 in the LSB-first serial stream, locks word
// framing on it and presents aligned 10-bit words with a valid strobe.
//   CRC_CKL        in   1   bit clock, one serial bit per rising edge
//   RST_L          in   1   asynchronous active-low reset
//   data_in        in   1   serial bit, bit 0 of each word first
//   RXPOL          in   1   1 = invert data_in before use
//   data_out       out  10  aligned word, bit 0 = first received bit
//   data_valid     out  1   one-cycle strobe for a new data_out word
//   is_comma       out  1   data_out is a K28.5 comma
//   locked         out  1   alignment FSM is in LOCKED
//   lock_loss_cnt  out  16  saturating LOCKED->HUNT count (RX_ALIGN_STATS_EN only)
//
// state  | meaning
// HUNT   | no framing; first comma anywhere sets the word phase
// VERIFY | framing set; counting aligned commas towards LOCK_CNT
// LOCKED | framing trusted; words emitted every 10 bits
module rx_word_align
    import serdes_pkg::*;
#(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2
) (
    input  logic              CRC_CKL,
    input  logic              RST_L,
    input  logic              data_in,
    input  logic              RXPOL,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              is_comma,
    output logic              locked
`ifdef RX_ALIGN_STATS_EN
    ,
    output logic [15:0]       lock_loss_cnt
`else
`endif
);

    localparam int CW = 4;
    localparam logic [CW-1:0] LOCK_M1   = CW'(LOCK_CNT - 1);
    localparam logic [CW-1:0] UNLOCK_M1 = CW'(UNLOCK_CNT - 1);

    align_state_t state, state_n;

    // Only the nine older bits need storage; the newest bit comes straight from the pin.
    logic [WORD_W-2:0] hist;
    logic [WORD_W-1:0] sr_n;
    logic              comma;
    logic              boundary;

    logic [3:0]        phase, phase_n;
    logic [CW-1:0]     good, good_n;
    logic [CW-1:0]     bad, bad_n;
    logic [WORD_W-1:0] dout_n;
    logic              valid_n, isc_n, locked_n;

    assign sr_n     = {data_in ^ RXPOL, hist};
    assign boundary = (phase == 4'd9);

    comma_detect u_comma_detect (
        .word  (sr_n),
        .comma (comma)
    );

    always_ff @(posedge CRC_CKL or negedge RST_L) begin
        if (!RST_L) begin
            state      <= HUNT;
            hist       <= '0;
            phase      <= '0;
            good       <= '0;
            bad        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            is_comma   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state      <= state_n;
            hist       <= sr_n[WORD_W-1:1];
            phase      <= phase_n;
            good       <= good_n;
            bad        <= bad_n;
            data_out   <= dout_n;
            data_valid <= valid_n;
            is_comma   <= isc_n;
            locked     <= locked_n;
        end
    end

    always_comb begin
        state_n  = state;
        phase_n  = boundary ? 4'd0 : phase + 4'd1;
        good_n   = good;
        bad_n    = bad;
        dout_n   = data_out;
        valid_n  = 1'b0;
        isc_n    = is_comma;
        locked_n = locked;

        case (state)
            HUNT: begin
                phase_n = phase;
                if (comma) begin
                    // phase 0 here means the next bit is bit 0 of a new word
                    phase_n = 4'd0;
                    good_n  = CW'(1);
                    if (LOCK_M1 == '0) begin
                        state_n  = LOCKED;
                        locked_n = 1'b1;
                        bad_n    = '0;
                    end else begin
                        state_n = VERIFY;
                    end
                end
            end
            VERIFY: begin
                if (boundary) begin
                    if (comma) begin
                        good_n = good + CW'(1);
                        if (good == LOCK_M1) begin
                            state_n  = LOCKED;
                            locked_n = 1'b1;
                            bad_n    = '0;
                        end
                    end
                end else if (comma) begin
                    phase_n = 4'd0;
                    good_n  = CW'(1);
                end
            end
            LOCKED: begin
                if (boundary) begin
                    dout_n  = sr_n;
                    valid_n = 1'b1;
                    isc_n   = comma;
                    if (comma) begin
                        bad_n = '0;
                    end
                end else if (comma) begin
                    // A lone stray comma only counts against the lock; framing stays put.
                    bad_n = bad + CW'(1);
                    if (bad == UNLOCK_M1) begin
                        state_n  = HUNT;
                        locked_n = 1'b0;
                        phase_n  = phase;
                        bad_n    = '0;
                        good_n   = '0;
                    end
                end
            end
            default: begin
                state_n  = HUNT;
                locked_n = 1'b0;
            end
        endcase
    end

`ifdef RX_ALIGN_STATS_EN
    always_ff @(posedge CRC_CKL or negedge RST_L) begin
        if (!RST_L) begin
            lock_loss_cnt <= '0;
        end else if (state == LOCKED && state_n == HUNT && lock_loss_cnt != 16'hFFFF) begin
            lock_loss_cnt <= lock_loss_cnt + 16'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_rx_word_align.sv
module tb_rx_word_align;

    logic       CRC_CKL = 1'b0;
    logic       RST_L   = 1'b0;
    logic       data_in = 1'b0;
    logic       RXPOL   = 1'b0;
    logic [9:0] data_out;
    logic       data_valid;
    logic       is_comma;
    logic       locked;
`ifdef RX_ALIGN_STATS_EN
    logic [15:0] lock_loss_cnt;
`endif

    rx_word_align dut (
        .CRC_CKL    (CRC_CKL),
        .RST_L      (RST_L),
        .data_in    (data_in),
        .RXPOL      (RXPOL),
        .data_out   (data_out),
        .data_valid (data_valid),
        .is_comma   (is_comma),
        .locked     (locked)
`ifdef RX_ALIGN_STATS_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    always #5 CRC_CKL = ~CRC_CKL;

    localparam int LOCK_N   = 3;
    localparam int UNLOCK_N = 2;

    int vecs = 0;
    int miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks absolute bit index and the index at which the next
    // framed word completes, plus a 10-bit history queue of decoded bits.
    bit         hist[$];
    int         m_mode;        // 0 hunt, 1 verify, 2 locked
    int         m_good, m_bad, m_n, m_next_end, m_lost;
    logic [9:0] m_dout;
    logic       m_valid, m_isc, m_locked;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 10; i++) hist.push_back(1'b0);
        m_mode = 0; m_good = 0; m_bad = 0; m_n = 0; m_next_end = -1; m_lost = 0;
        m_dout = '0; m_valid = 1'b0; m_isc = 1'b0; m_locked = 1'b0;
    endtask

    task automatic model_step(input bit b);
        logic [9:0] w;
        bit         c, at_end;
        hist.push_back(b);
        void'(hist.pop_front());
        for (int i = 0; i < 10; i++) w[i] = hist[i];
        c = (w == 10'h17C) || (w == 10'h283);
        m_n++;
        at_end  = (m_n == m_next_end);
        m_valid = 1'b0;
        if (at_end) m_next_end = m_n + 10;
        case (m_mode)
            0: if (c) begin
                m_next_end = m_n + 10;
                m_good = 1;
                if (m_good == LOCK_N) begin m_mode = 2; m_locked = 1'b1; m_bad = 0; end
                else m_mode = 1;
            end
            1: if (at_end) begin
                if (c) begin
                    m_good++;
                    if (m_good == LOCK_N) begin m_mode = 2; m_locked = 1'b1; m_bad = 0; end
                end
            end else if (c) begin
                m_next_end = m_n + 10;
                m_good = 1;
            end
            default: if (at_end) begin
                m_valid = 1'b1; m_dout = w; m_isc = c;
                if (c) m_bad = 0;
            end else if (c) begin
                m_bad++;
                if (m_bad == UNLOCK_N) begin
                    m_mode = 0; m_locked = 1'b0; m_bad = 0; m_good = 0;
                    if (m_lost < 65535) m_lost++;
                end
            end
        endcase
    endtask

    task automatic compare_model();
        check("mdl_data_out", data_out, m_dout);
        check("mdl_data_valid", data_valid, m_valid);
        check("mdl_is_comma", is_comma, m_isc);
        check("mdl_locked", locked, m_locked);
`ifdef RX_ALIGN_STATS_EN
        check("mdl_lock_loss_cnt", lock_loss_cnt, m_lost);
`endif
    endtask

    task automatic send_bit(input bit line, input bit pol);
        data_in = line;
        RXPOL   = pol;
        @(posedge CRC_CKL);
        #1;
        model_step(line ^ pol);
        compare_model();
    endtask

    // The line carries the word inverted when pol=1, so the decoded word is always w.
    task automatic send_word(input logic [9:0] w, input bit pol);
        for (int i = 0; i < 10; i++) send_bit(w[i] ^ pol, pol);
    endtask

    task automatic async_reset_check();
        RST_L = 1'b0;
        #1;
        check("rst_data_out", data_out, 10'h000);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_is_comma", is_comma, 1'b0);
        check("rst_locked", locked, 1'b0);
`ifdef RX_ALIGN_STATS_EN
        check("rst_lock_loss_cnt", lock_loss_cnt, 16'h0000);
`endif
        model_reset();
        #2;
        RST_L = 1'b1;
    endtask

    typedef struct {
        logic [9:0] word;
        logic       exp_locked;
        logic       exp_valid;
        logic [9:0] exp_dout;
        logic       exp_isc;
    } vec_t;

    vec_t tbl[10];

    task automatic run_table(input bit pol);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), pol);
        for (int i = 0; i < 10; i++) begin
            send_word(tbl[i].word, pol);
            check($sformatf("tbl%0d_pol%0d_locked", i, pol), locked, tbl[i].exp_locked);
            check($sformatf("tbl%0d_pol%0d_valid", i, pol), data_valid, tbl[i].exp_valid);
            check($sformatf("tbl%0d_pol%0d_data_out", i, pol), data_out, tbl[i].exp_dout);
            check($sformatf("tbl%0d_pol%0d_is_comma", i, pol), is_comma, tbl[i].exp_isc);
        end
    endtask

    initial begin
        tbl[0] = '{10'h17C, 1'b0, 1'b0, 10'h000, 1'b0};
        tbl[1] = '{10'h283, 1'b0, 1'b0, 10'h000, 1'b0};
        tbl[2] = '{10'h17C, 1'b1, 1'b0, 10'h000, 1'b0};
        tbl[3] = '{10'h283, 1'b1, 1'b1, 10'h283, 1'b1};
        tbl[4] = '{10'h155, 1'b1, 1'b1, 10'h155, 1'b0};
        tbl[5] = '{10'h2AA, 1'b1, 1'b1, 10'h2AA, 1'b0};
        tbl[6] = '{10'h17C, 1'b1, 1'b1, 10'h17C, 1'b1};
        tbl[7] = '{10'h155, 1'b1, 1'b1, 10'h155, 1'b0};
        tbl[8] = '{10'h283, 1'b1, 1'b1, 10'h283, 1'b1};
        tbl[9] = '{10'h17C, 1'b1, 1'b1, 10'h17C, 1'b1};

        model_reset();
        #1;
        compare_model();
        #3;
        RST_L = 1'b1;

        // Idle comma stream with payload, normal polarity.
        run_table(1'b0);

        // Framing slips by 3 bits: two shifted commas drop lock, three more relock.
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        send_word(10'h17C, 1'b0);
        check("slip_first_locked", locked, 1'b1);
        send_word(10'h283, 1'b0);
        check("slip_second_locked", locked, 1'b0);
`ifdef RX_ALIGN_STATS_EN
        check("slip_lock_loss_cnt", lock_loss_cnt, 16'd1);
`endif
        send_word(10'h17C, 1'b0);
        send_word(10'h283, 1'b0);
        check("relock_early", locked, 1'b0);
        send_word(10'h17C, 1'b0);
        check("relock_third", locked, 1'b1);

        // Stray comma straddling two payload words (offset 5), twice, each followed
        // by an aligned comma; lock must survive both.
        for (int k = 0; k < 2; k++) begin
            send_word(10'h380, 1'b0);
            check("stray_word_a", data_out, 10'h380);
            send_word(10'h00B, 1'b0);
            check("stray_locked", locked, 1'b1);
            check("stray_word_b_isc", is_comma, 1'b0);
            send_word(10'h17C, 1'b0);
            check("stray_realigned_dout", data_out, 10'h17C);
            check("stray_realigned_isc", is_comma, 1'b1);
            check("stray_realigned_locked", locked, 1'b1);
        end

        // Asynchronous reset while locked and just after a strobe.
        check("pre_reset_valid", data_valid, 1'b1);
        async_reset_check();

        // Same stream on an inverted line.
        run_table(1'b1);

        // Randomized traffic against the model.
        for (int it = 0; it < 1500; it++) begin
            int r;
            bit pol;
            r   = $urandom_range(0, 99);
            pol = 1'($urandom_range(0, 1));
            if (r < 45)      send_word(($urandom_range(0, 1) != 0) ? 10'h17C : 10'h283, pol);
            else if (r < 80) send_word(10'($urandom_range(0, 1023)), pol);
            else if (r < 92) begin
                int n;
                n = $urandom_range(1, 9);
                for (int j = 0; j < n; j++) send_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            else if (r < 99) begin
                for (int j = 0; j < 3; j++) send_word(10'h17C, pol);
            end
            else async_reset_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
